// File: rtl/mc_ctrl_unit.sv
// Multicycle control unit for the ARM-subset datapath: FSM sequencing, NZCV flags, condition gating.
// Optional perf counters (retired/squashed instructions) are built only when MC_CTRL_PERF_EN is defined.
module mc_ctrl_unit #(
    parameter logic [3:0] FLAGS_RST = 4'b0000,
    parameter int         CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cond,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic [3:0]       rd,
    input  logic [3:0]       alu_flags,
    output logic             ir_write,
    output logic             adr_src,
    output logic             pc_write,
    output logic             pc_src,
    output logic             branch,
    output logic             reg_write,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_control,
    output logic [1:0]       imm_src,
    output logic [1:0]       reg_src,
    output logic [3:0]       state,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ok_q, cond_ok_d;

    logic       dp_valid;
    logic       dp_arith;
    logic [1:0] dp_ctl;

    logic ir_write_c, pc_write_c, reg_write_c, mem_write_c;

    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        logic res;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'b0000: res = z;
            4'b0001: res = !z;
            4'b0010: res = cf;
            4'b0011: res = !cf;
            4'b0100: res = n;
            4'b0101: res = !n;
            4'b0110: res = v;
            4'b0111: res = !v;
            4'b1000: res = cf && !z;
            4'b1001: res = !cf || z;
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = !z && (n == v);
            4'b1101: res = z || (n != v);
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    always_comb begin
        dp_valid = 1'b1;
        dp_arith = 1'b0;
        dp_ctl   = 2'b00;
        case (funct[4:1])
            4'b0100: dp_arith = 1'b1;
            4'b0010: begin dp_ctl = 2'b01; dp_arith = 1'b1; end
            4'b0000: dp_ctl = 2'b10;
            4'b1100: dp_ctl = 2'b11;
            default: dp_valid = 1'b0;
        endcase
    end

    // cond_ok is captured once in DECODE so the instruction's own flag write cannot regate it.
    always_comb begin
        state_d     = S_FETCH;
        flags_d     = flags_q;
        cond_ok_d   = cond_ok_q;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        adr_src     = 1'b0;
        pc_src      = 1'b0;
        branch      = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        alu_control = 2'b00;
        imm_src     = 2'b00;
        reg_src     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                cond_ok_d = cond_check(cond, flags_q);
                reg_src   = (op == 2'b01) ? 2'b10 : 2'b00;
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_EXECR, S_EXECI: begin
                alu_src     = (state_q == S_EXECI);
                alu_control = dp_ctl;
                state_d     = S_ALUWB;
                if (cond_ok_q && funct[0] && dp_valid) begin
                    flags_d[3:2] = alu_flags[3:2];
                    if (dp_arith) flags_d[1:0] = alu_flags[1:0];
                end
            end
            S_ALUWB: begin
                if (rd == 4'd15) begin
                    pc_src     = 1'b1;
                    pc_write_c = cond_ok_q && dp_valid;
                end else begin
                    reg_write_c = cond_ok_q && dp_valid;
                end
            end
            S_MEMADR: begin
                alu_src = 1'b1;
                imm_src = 2'b01;
                state_d = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                if (rd == 4'd15) begin
                    pc_src     = 1'b1;
                    pc_write_c = cond_ok_q;
                end else begin
                    reg_write_c = cond_ok_q;
                end
            end
            S_MEMWR: begin
                adr_src     = 1'b1;
                mem_write_c = cond_ok_q;
            end
            S_BRANCH: begin
                branch     = 1'b1;
                reg_src    = 2'b01;
                alu_src    = 1'b1;
                imm_src    = 2'b10;
                pc_src     = 1'b1;
                pc_write_c = cond_ok_q;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            flags_q   <= FLAGS_RST;
            cond_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ok_q <= cond_ok_d;
        end
    end

    // The reset state is FETCH, so enables must be masked by reset itself while it is held.
    assign ir_write  = ir_write_c  && reset;
    assign pc_write  = pc_write_c  && reset;
    assign reg_write = reg_write_c && reset;
    assign mem_write = mem_write_c && reset;
    assign state     = state_q;
    assign flags     = flags_q;

`ifdef MC_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] retired_q, retired_d, squash_q, squash_d;
    logic             terminal;

    always_comb begin
        retired_d = retired_q;
        squash_d  = squash_q;
        terminal  = (state_q == S_ALUWB) || (state_q == S_MEMWB) ||
                    (state_q == S_MEMWR) || (state_q == S_BRANCH);
        if (state_q == S_DECODE && op == 2'b11) begin
            retired_d = retired_q + CNT_ONE;
        end else if (terminal) begin
            if (cond_ok_q) retired_d = retired_q + CNT_ONE;
            else           squash_d  = squash_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
            squash_q  <= '0;
        end else begin
            retired_q <= retired_d;
            squash_q  <= squash_d;
        end
    end

    assign retired_cnt = retired_q;
    assign squash_cnt  = squash_q;
`else
    assign retired_cnt = '0;
    assign squash_cnt  = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit: directed instruction table, random instructions against an
// instruction-level reference model, and an asynchronous reset abort in the middle of a load.
module tb_mc_ctrl_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  alu_flags;
    logic        ir_write, adr_src, pc_write, pc_src, branch, reg_write, mem_write, mem_to_reg, alu_src;
    logic [1:0]  alu_control, imm_src, reg_src;
    logic [3:0]  state, flags;
    logic [31:0] retired_cnt, squash_cnt;

`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    mc_ctrl_unit #(.FLAGS_RST(4'b0000), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
        .alu_flags(alu_flags), .ir_write(ir_write), .adr_src(adr_src), .pc_write(pc_write),
        .pc_src(pc_src), .branch(branch), .reg_write(reg_write), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_control(alu_control),
        .imm_src(imm_src), .reg_src(reg_src), .state(state), .flags(flags),
        .retired_cnt(retired_cnt), .squash_cnt(squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] aluf;
        int         lat;
        int         regw;
        int         pcx;
        int         memw;
        logic [3:0] flags;
    } vec_t;

    vec_t tbl[14];

    int checks = 0;
    int errors = 0;

    // observations of one instruction
    int         o_lat, o_ir, o_pc, o_reg, o_mem, o_m2r, o_adr, o_asrc, o_br;
    logic [3:0] o_seq[8];
    logic [1:0] o_actl[8], o_imm[8], o_rs[8];
    bit         o_timeout;

    // reference model state and expectations
    logic [3:0] m_flags;
    int         m_ret, m_sq;
    int         e_lat, e_reg, e_pcx, e_mem, e_m2r, e_adr, e_asrc, e_br, e_actl, e_imm, e_rs;
    logic [3:0] e_seq[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit condHolds(input logic [3:0] c, input logic [3:0] f);
        bit r;
        case (c[3:1])
            3'd0: r = f[2];
            3'd1: r = f[1];
            3'd2: r = f[3];
            3'd3: r = f[0];
            3'd4: r = f[1] && !f[2];
            3'd5: r = (f[3] == f[0]);
            3'd6: r = !f[2] && (f[3] == f[0]);
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    // Instruction-level model: what the whole instruction should do, and the resulting flags/counters.
    task automatic modelInstr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                              input logic [3:0] r, input logic [3:0] af);
        bit ok, valid, arith, we;
        int ctl;
        ok = condHolds(c, m_flags);
        e_reg = 0; e_pcx = 0; e_mem = 0; e_m2r = 0; e_adr = 0; e_asrc = 0; e_br = 0;
        e_actl = 0; e_imm = 0; e_rs = (o == 2'b01) ? 2 : 0;
        e_seq = {4'd0, 4'd1};
        case (o)
            2'b00: begin
                valid = 1; arith = 0; ctl = 0;
                if (f[4:1] == 4'd4)       begin ctl = 0; arith = 1; end
                else if (f[4:1] == 4'd2)  begin ctl = 1; arith = 1; end
                else if (f[4:1] == 4'd0)  ctl = 2;
                else if (f[4:1] == 4'd12) ctl = 3;
                else valid = 0;
                e_lat = 4; e_actl = ctl; e_asrc = f[5];
                e_seq.push_back(f[5] ? 4'd7 : 4'd6);
                e_seq.push_back(4'd8);
                we = ok && valid;
                if (r == 4'd15) e_pcx = we; else e_reg = we;
                if (we && f[0]) begin
                    m_flags[3:2] = af[3:2];
                    if (arith) m_flags[1:0] = af[1:0];
                end
            end
            2'b01: begin
                e_asrc = 1; e_adr = 1; e_imm = 1;
                e_seq.push_back(4'd2);
                if (f[0]) begin
                    e_lat = 5; e_m2r = 1;
                    e_seq.push_back(4'd3);
                    e_seq.push_back(4'd4);
                    if (r == 4'd15) e_pcx = ok; else e_reg = ok;
                end else begin
                    e_lat = 4; e_mem = ok;
                    e_seq.push_back(4'd5);
                end
            end
            2'b10: begin
                e_lat = 3; e_br = 1; e_asrc = 1; e_imm = 2; e_pcx = ok;
                e_seq.push_back(4'd9);
            end
            default: e_lat = 2;
        endcase
        if (o == 2'b11)  m_ret++;
        else if (ok)     m_ret++;
        else             m_sq++;
    endtask

    // Runs one instruction from the FETCH cycle until the FSM is back in FETCH (bounded).
    task automatic applyStimulus(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                                 input logic [3:0] r, input logic [3:0] af);
        int cyc;
        bit done;
        cond = c; op = o; funct = f; rd = r; alu_flags = af;
        o_ir = 0; o_pc = 0; o_reg = 0; o_mem = 0; o_m2r = 0; o_adr = 0; o_asrc = 0; o_br = 0;
        cyc = 0; done = 0;
        while (!done && cyc < 8) begin
            #1;
            o_seq[cyc] = state; o_actl[cyc] = alu_control; o_imm[cyc] = imm_src; o_rs[cyc] = reg_src;
            o_ir += int'(ir_write); o_pc += int'(pc_write); o_reg += int'(reg_write);
            o_mem += int'(mem_write); o_m2r += int'(mem_to_reg); o_adr += int'(adr_src);
            o_asrc += int'(alu_src); o_br += int'(branch);
            cyc++;
            @(posedge clk);
            #1;
            if (state == 4'd0) done = 1;
        end
        o_lat = cyc;
        o_timeout = !done;
    endtask

    task automatic checkAgainstModel(input string tag, input logic [1:0] o);
        bit seq_ok;
        checkOutput({tag, " timeout"}, int'(o_timeout), 0);
        checkOutput({tag, " latency"}, o_lat, e_lat);
        seq_ok = (o_lat == e_seq.size());
        for (int i = 0; i < o_lat && i < e_seq.size(); i++) if (o_seq[i] !== e_seq[i]) seq_ok = 0;
        checkOutput({tag, " state_seq"}, int'(seq_ok), 1);
        checkOutput({tag, " ir_write"}, o_ir, 1);
        checkOutput({tag, " pc_write"}, o_pc, 1 + e_pcx);
        checkOutput({tag, " reg_write"}, o_reg, e_reg);
        checkOutput({tag, " mem_write"}, o_mem, e_mem);
        checkOutput({tag, " mem_to_reg"}, o_m2r, e_m2r);
        checkOutput({tag, " adr_src"}, o_adr, e_adr);
        checkOutput({tag, " alu_src"}, o_asrc, e_asrc);
        checkOutput({tag, " branch"}, o_br, e_br);
        checkOutput({tag, " reg_src_dec"}, int'(o_rs[1]), e_rs);
        if (o == 2'b00) checkOutput({tag, " alu_control"}, int'(o_actl[2]), e_actl);
        if (o != 2'b11) checkOutput({tag, " imm_src"}, int'(o_imm[2]), e_imm);
        if (o == 2'b10) checkOutput({tag, " reg_src_br"}, int'(o_rs[2]), 1);
        checkOutput({tag, " flags"}, int'(flags), int'(m_flags));
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, " retired_cnt"}, int'(retired_cnt), PERF ? m_ret : 0);
        checkOutput({tag, " squash_cnt"}, int'(squash_cnt), PERF ? m_sq : 0);
    endtask

    initial begin
        int         budget;
        logic [3:0] rc, rr, ra;
        logic [1:0] ro;
        logic [5:0] rf;

        //        cond   op     funct      rd     aluf   lat reg pcx mem flags
        tbl[0]  = '{4'hE, 2'b00, 6'b101000, 4'd3,  4'hF, 4, 1, 0, 0, 4'h0}; // ADDI
        tbl[1]  = '{4'hE, 2'b00, 6'b000101, 4'd2,  4'h4, 4, 1, 0, 0, 4'h4}; // SUBS -> Z
        tbl[2]  = '{4'h0, 2'b10, 6'b000000, 4'd0,  4'h0, 3, 0, 1, 0, 4'h4}; // BEQ taken
        tbl[3]  = '{4'hE, 2'b00, 6'b000001, 4'd1,  4'hB, 4, 1, 0, 0, 4'h8}; // ANDS keeps CV
        tbl[4]  = '{4'h0, 2'b10, 6'b000000, 4'd0,  4'h0, 3, 0, 0, 0, 4'h8}; // BEQ not taken
        tbl[5]  = '{4'hE, 2'b00, 6'b011000, 4'd15, 4'h0, 4, 0, 1, 0, 4'h8}; // ORR pc
        tbl[6]  = '{4'hE, 2'b01, 6'b011001, 4'd15, 4'h0, 5, 0, 1, 0, 4'h8}; // LDR pc
        tbl[7]  = '{4'h1, 2'b01, 6'b011000, 4'd5,  4'h0, 4, 0, 0, 1, 4'h8}; // STRNE Z=0
        tbl[8]  = '{4'hE, 2'b00, 6'b001001, 4'd6,  4'h7, 4, 1, 0, 0, 4'h7}; // ADDS all of NZCV
        tbl[9]  = '{4'h1, 2'b01, 6'b011000, 4'd5,  4'h0, 4, 0, 0, 0, 4'h7}; // STRNE Z=1
        tbl[10] = '{4'hF, 2'b11, 6'b000000, 4'd0,  4'h0, 2, 0, 0, 0, 4'h7}; // NOP
        tbl[11] = '{4'hE, 2'b00, 6'b011111, 4'd7,  4'h8, 4, 0, 0, 0, 4'h7}; // bad cmd
        tbl[12] = '{4'hF, 2'b00, 6'b001001, 4'd8,  4'h8, 4, 0, 0, 0, 4'h7}; // never
        tbl[13] = '{4'hC, 2'b00, 6'b001000, 4'd4,  4'h0, 4, 0, 0, 0, 4'h7}; // GT false

        reset = 1'b0; cond = '0; op = '0; funct = '0; rd = '0; alu_flags = '0;
        m_flags = 4'h0; m_ret = 0; m_sq = 0;
        #2;
        checkOutput("rst state", int'(state), 0);
        checkOutput("rst flags", int'(flags), 0);
        checkOutput("rst ir_write", int'(ir_write), 0);
        checkOutput("rst pc_write", int'(pc_write), 0);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            modelInstr(tbl[i].cond, tbl[i].op, tbl[i].funct, tbl[i].rd, tbl[i].aluf);
            applyStimulus(tbl[i].cond, tbl[i].op, tbl[i].funct, tbl[i].rd, tbl[i].aluf);
            checkOutput($sformatf("tbl%0d lat", i), o_lat, tbl[i].lat);
            checkOutput($sformatf("tbl%0d regw", i), o_reg, tbl[i].regw);
            checkOutput($sformatf("tbl%0d pcw", i), o_pc, 1 + tbl[i].pcx);
            checkOutput($sformatf("tbl%0d memw", i), o_mem, tbl[i].memw);
            checkOutput($sformatf("tbl%0d flags", i), int'(flags), int'(tbl[i].flags));
            checkAgainstModel($sformatf("tbl%0d", i), tbl[i].op);
        end
        checkOutput("tbl retired", int'(retired_cnt), PERF ? 10 : 0);
        checkOutput("tbl squashed", int'(squash_cnt), PERF ? 4 : 0);

        for (int n = 0; n < 60; n++) begin
            rc = 4'($urandom_range(0, 15));
            ro = 2'($urandom_range(0, 3));
            rf = 6'($urandom_range(0, 63));
            rr = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            if ((n % 3) == 0) rc = 4'hE;
            if ((n % 4) == 0) rf[4:1] = 4'($urandom_range(0, 1) ? 4'd4 : 4'd2);
            modelInstr(rc, ro, rf, rr, ra);
            applyStimulus(rc, ro, rf, rr, ra);
            checkAgainstModel($sformatf("rnd%0d", n), ro);
        end
        checkCounters("rnd");

        // Abort a load while it sits in MEMRD.
        cond = 4'hE; op = 2'b01; funct = 6'b011001; rd = 4'd9; alu_flags = 4'h0;
        budget = 0;
        while (state != 4'd3 && budget < 10) begin
            @(posedge clk); #1;
            budget++;
        end
        checkOutput("reach MEMRD", int'(state), 3);
        reset = 1'b0;
        m_flags = 4'h0; m_ret = 0; m_sq = 0;
        #1;
        checkOutput("abort state", int'(state), 0);
        checkOutput("abort flags", int'(flags), 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #2;
            checkOutput("abort ir_write", int'(ir_write), 0);
            checkOutput("abort pc_write", int'(pc_write), 0);
            checkOutput("abort reg_write", int'(reg_write), 0);
            checkOutput("abort mem_write", int'(mem_write), 0);
            checkOutput("abort state hold", int'(state), 0);
        end
        checkCounters("abort");
        @(negedge clk);
        reset = 1'b1;

        modelInstr(4'hE, 2'b00, 6'b101000, 4'd3, 4'h0);
        applyStimulus(4'hE, 2'b00, 6'b101000, 4'd3, 4'h0);
        checkAgainstModel("post_rst", 2'b00);
        checkCounters("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
